// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with credit-limited requests, tag queue and output buffer
module ifetch #(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] RESETVEC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    // Pointer width for the DEPTH-entry circular buffers; counters are 3 bits to hold 0..4.
    localparam int unsigned PW = (DEPTH == 4) ? 2 : 1;

    generate
        if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
            $fatal(1, "ifetch: XLEN must be 32 or 64");
        end
        if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
            $fatal(1, "ifetch: DEPTH must be 2 or 4");
        end
    endgenerate

    localparam logic [XLEN-1:0] RESET_PC = {RESETVEC[XLEN-1:2], 2'b00};

    // Architectural fetch state.
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      inflight_q, inflight_d;
    logic [2:0]      drop_q, drop_d;

    // Tag queue: PCs of outstanding requests, oldest at tag_rd_q.
    logic [XLEN-1:0] tag_mem [DEPTH];
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;

    // Output buffer of fetched {pc, instr} pairs.
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];
    logic [PW-1:0]   fifo_rd_q, fifo_rd_d;
    logic [PW-1:0]   fifo_wr_q, fifo_wr_d;
    logic [2:0]      fifo_cnt_q, fifo_cnt_d;

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;

    // Low address bits of a redirect target are forced to zero, so they are never read.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake decode: a request slot exists only while outstanding plus buffered stays below DEPTH.
    always_comb begin
        credit_ok      = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < 4'(DEPTH);
        imem_req_valid = !reset && !redirect_valid && credit_ok;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = !reset && imem_rsp_valid && (inflight_q != 3'd0);
        push           = rsp_fire && !redirect_valid && (drop_q == 3'd0);
        out_valid      = !reset && !redirect_valid && (fifo_cnt_q != 3'd0);
        pop            = out_valid && out_ready;
        imem_req_addr  = pc_q;
        out_pc         = fifo_pc[fifo_rd_q];
        out_instr      = fifo_instr[fifo_rd_q];
    end

    // Next-state: redirect resets the PC and buffer and turns every response still owed into a drop.
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + {2'b00, req_fire} - {2'b00, rsp_fire};
        drop_d     = drop_q;
        tag_wr_d   = req_fire ? tag_wr_q + PW'(1) : tag_wr_q;
        tag_rd_d   = rsp_fire ? tag_rd_q + PW'(1) : tag_rd_q;
        fifo_rd_d  = pop  ? fifo_rd_q + PW'(1) : fifo_rd_q;
        fifo_wr_d  = push ? fifo_wr_q + PW'(1) : fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};

        if (redirect_valid) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = inflight_q - {2'b00, rsp_fire};
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = 3'd0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_fire && drop_q != 3'd0) begin
                drop_d = drop_q - 3'd1;
            end
        end
    end

    // State register; reset abandons everything outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 3'd0;
            drop_q     <= 3'd0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= 3'd0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage arrays: no reset needed, occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_pc[fifo_wr_q]    <= tag_mem[tag_rd_q];
            fifo_instr[fifo_wr_q] <= imem_rsp_data;
        end
    end

    a_rsp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && inflight_q == 3'd0));

    a_push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_cnt_q == 3'(DEPTH)));

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a queue-based reference model
module tb_ifetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    ifetch #(
        .XLEN     (32),
        .RESETVEC (64'h0000_0000_8000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: fetch state as plain counters and queues.
    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_t;

    logic [31:0] m_pc;
    int          m_inflight;
    int          m_drop;
    logic [31:0] m_tags[$];
    logic [63:0] m_fifo[$];
    mem_t        mq[$];
    int          cyc      = 0;
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [15:0] seq      = 16'h0;
    logic [31:0] out_log[$];
    logic [31:0] req_log[$];

    task automatic model_reset();
        m_pc       = RV;
        m_inflight = 0;
        m_drop     = 0;
        m_tags.delete();
        m_fifo.delete();
        mq.delete();
        last_due   = 0;
    endtask

    // One clock cycle: drive at negedge, check after settling, advance model and DUT together.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rp,
                        input logic rdy, input logic ordy);
        logic        e_req;
        logic        e_out;
        logic        rsp;
        logic [31:0] rdata;
        logic [31:0] t;
        mem_t        m;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_req_ready = rdy;
        out_ready      = ordy;
        rsp            = !rst && mq.size() > 0 && mq[0].due <= cyc;
        rdata          = rsp ? mq[0].data : $urandom;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        #1;
        e_req = !rst && !rv && (m_inflight + m_fifo.size() < DEPTH);
        e_out = !rst && !rv && m_fifo.size() > 0;
        check("req_valid", {63'd0, imem_req_valid}, {63'd0, e_req});
        if (e_req) check("req_addr", {32'd0, imem_req_addr}, {32'd0, m_pc});
        check("out_valid", {63'd0, out_valid}, {63'd0, e_out});
        if (e_out) begin
            check("out_pc", {32'd0, out_pc}, {32'd0, m_fifo[0][63:32]});
            check("out_instr", {32'd0, out_instr}, {32'd0, m_fifo[0][31:0]});
        end
        if (out_valid && out_ready) out_log.push_back(out_pc);
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);

        if (rst) begin
            model_reset();
        end else begin
            if (e_out && ordy) void'(m_fifo.pop_front());
            if (rsp) begin
                void'(mq.pop_front());
                t = m_tags.pop_front();
                m_inflight--;
                if (!rv) begin
                    if (m_drop > 0) m_drop--;
                    else m_fifo.push_back({t, rdata});
                end
            end
            if (rv) begin
                m_drop = m_inflight;
                m_fifo.delete();
                m_pc = {rp[31:2], 2'b00};
            end else if (e_req && rdy) begin
                m_tags.push_back(m_pc);
                m.due = cyc + int'($urandom_range(lat_max, lat_min));
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                m.data = {seq, m_pc[17:2]};
                seq++;
                mq.push_back(m);
                m_pc = m_pc + 32'd4;
                m_inflight++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        out_log.delete();
        req_log.delete();
    endtask

    int n_stall_req;

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        out_ready      = 1'b0;
        model_reset();
        @(negedge clk);

        // Streaming after reset with single-cycle memory.
        do_reset(3);
        check("rst_addr", {32'd0, imem_req_addr}, {32'd0, RV});
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("stream_pc0", {32'd0, out_log[0]}, 64'h8000_0000);
        check("stream_pc1", {32'd0, out_log[1]}, 64'h8000_0004);
        check("stream_pc2", {32'd0, out_log[2]}, 64'h8000_0008);
        check("stream_req0", {32'd0, req_log[0]}, 64'h8000_0000);

        // Decode stalled: credits cap issue at DEPTH, then resume without loss.
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_stall_req = req_log.size();
        check("stall_reqs", 64'(n_stall_req), 64'd2);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            check("resume_seq", {32'd0, out_log[i]}, {32'd0, RV + 32'(4 * i)});

        // Redirect with two stale requests outstanding at latency 3.
        do_reset(2);
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        req_log.delete();
        step(1'b0, 1'b1, 32'h0000_1002, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_out0", {32'd0, out_log[0]}, 64'h1000);
        check("redir_req0", {32'd0, req_log[0]}, 64'h1000);

        // Redirect in the same cycle as a response arrival.
        do_reset(2);
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("coinc_rsp_pending", {63'd0, mq.size() > 0 && mq[0].due <= cyc}, 64'd1);
        out_log.delete();
        step(1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("coinc_out0", {32'd0, out_log[0]}, 64'h2000);

        // Address wrap at the top of the 32-bit space.
        out_log.delete();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_pc0", {32'd0, out_log[0]}, 64'hFFFF_FFFC);
        check("wrap_pc1", {32'd0, out_log[1]}, 64'h0000_0000);

        // Reset mid-operation with requests outstanding and data buffered.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        req_log.delete();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("rst_mid_req0", {32'd0, req_log[0]}, {32'd0, RV});
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(19) == 0,
                 ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom,
                 $urandom_range(9) < 7,
                 $urandom_range(9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
